// File: rtl/bpfcpu_pkg.sv
// Shared definitions for the BPF CPU run controller: FSM state encoding,
// verdict field layout and default sizing constants.
package bpfcpu_pkg;

   // State encoding of the per-packet lifecycle
   localparam logic [2:0] ST_IDLE    = 3'd0;
   localparam logic [2:0] ST_LOAD    = 3'd1;
   localparam logic [2:0] ST_RUN     = 3'd2;
   localparam logic [2:0] ST_REPORT  = 3'd3;
   localparam logic [2:0] ST_RELEASE = 3'd4;

   typedef enum logic [2:0] {
      IDLE    = ST_IDLE,
      LOAD    = ST_LOAD,
      RUN     = ST_RUN,
      REPORT  = ST_REPORT,
      RELEASE = ST_RELEASE
   } run_state_t;

   // Verdict fields held stable while the verdict is offered
   typedef struct packed {
      logic acc;       // 1 = accept, 0 = reject
      logic timeout;   // reject caused by the instruction watchdog
   } verdict_t;

   // Default sizing
   localparam int BPF_DEF_PLEN_WIDTH     = 10;
   localparam int BPF_DEF_MAX_INSNS      = 4096;
   localparam int BPF_DEF_INSN_CNT_WIDTH = 16;
   localparam int BPF_DEF_STAT_WIDTH     = 32;

   function automatic verdict_t mk_verdict(input logic acc, input logic timeout);
      verdict_t v;
      v.acc     = acc;
      v.timeout = timeout;
      return v;
   endfunction

endpackage

// File: rtl/bpf_insn_watchdog.sv
// Instruction-count watchdog: counts fetches while the core runs, saturates
// at MAX_INSNS and flags expiry once the budget has been used up.
module bpf_insn_watchdog #(
   parameter int CNT_WIDTH = 16,
   parameter int MAX_INSNS = 4096
) (
   input  logic clk,
   input  logic rst,
   input  logic clear,
   input  logic count_en,
   input  logic run_en,
   output logic expired
);

   localparam logic [CNT_WIDTH-1:0] MAX_CNT = CNT_WIDTH'(MAX_INSNS);

   logic [CNT_WIDTH-1:0] cnt_reg;

   // Count fetches during RUN, hold at the budget, clear on a new packet
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         cnt_reg <= '0;
      end else if (clear) begin
         cnt_reg <= '0;
      end else if (run_en && count_en && (cnt_reg != MAX_CNT)) begin
         cnt_reg <= cnt_reg + 1'b1;
      end
   end

   assign expired = (cnt_reg == MAX_CNT);

endmodule

// File: rtl/bpfcpu_run_ctrl.sv
// Per-packet run controller for the BPF CPU core: launches the core on a
// ready packet, collects its verdict, offers it over valid/ready, releases
// the packet buffer and keeps saturating accept/reject statistics.
// Optional feature: define BPF_WATCHDOG_EN to add the instruction watchdog
// and its timeout-reject path; without it RUN exits only on a core strobe.
module bpfcpu_run_ctrl
   import bpfcpu_pkg::*;
#(
   parameter int PLEN_WIDTH     = BPF_DEF_PLEN_WIDTH,
   parameter int INSN_CNT_WIDTH = BPF_DEF_INSN_CNT_WIDTH,
   parameter int MAX_INSNS      = BPF_DEF_MAX_INSNS,
   parameter int STAT_WIDTH     = BPF_DEF_STAT_WIDTH
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  pkt_ready,
   input  logic [PLEN_WIDTH-1:0] pkt_len,
   output logic                  pkt_done,
   output logic                  core_rst,
   output logic [PLEN_WIDTH-1:0] core_plen,
   input  logic                  core_acc,
   input  logic                  core_rej,
   input  logic                  core_inst_rd_en,
   output logic                  verdict_valid,
   input  logic                  verdict_ready,
   output logic                  verdict_acc,
   output logic                  verdict_timeout,
   output logic [PLEN_WIDTH-1:0] verdict_len,
   output logic [STAT_WIDTH-1:0] stat_acc,
   output logic [STAT_WIDTH-1:0] stat_rej,
   output logic                  busy
);

   run_state_t            state_reg, state_next;
   verdict_t              verdict_reg, verdict_next;
   logic [PLEN_WIDTH-1:0] plen_reg;
   logic [STAT_WIDTH-1:0] stat_acc_reg, stat_rej_reg;
   logic                  core_rst_reg, verdict_valid_reg, pkt_done_reg, busy_reg;
   logic                  wd_clear, wd_expired, handshake;

   assign handshake = verdict_valid_reg && verdict_ready;

`ifdef BPF_WATCHDOG_EN
   bpf_insn_watchdog #(
      .CNT_WIDTH (INSN_CNT_WIDTH),
      .MAX_INSNS (MAX_INSNS)
   ) u_watchdog (
      .clk      (clk),
      .rst      (rst),
      .clear    (wd_clear),
      .count_en (core_inst_rd_en),
      .run_en   (state_reg == RUN),
      .expired  (wd_expired)
   );
   assign verdict_timeout = verdict_reg.timeout;
`else
   logic unused_wd;
   assign unused_wd       = ^{core_inst_rd_en, wd_clear, verdict_reg.timeout,
                              INSN_CNT_WIDTH[0], MAX_INSNS[0]};
   assign wd_expired      = 1'b0;
   assign verdict_timeout = 1'b0;
`endif

   // Next-state and verdict selection; strobes only matter in RUN
   always_comb begin
      state_next   = state_reg;
      verdict_next = verdict_reg;
      wd_clear     = 1'b0;
      case (state_reg)
         IDLE: begin
            if (pkt_ready) state_next = LOAD;
         end
         LOAD: begin
            wd_clear = 1'b1;
            if (pkt_len == '0) begin
               state_next   = REPORT;
               verdict_next = mk_verdict(1'b0, 1'b0);
            end else begin
               state_next   = RUN;
            end
         end
         RUN: begin
            // reject is pessimistic and wins over accept; strobes beat expiry
            if (core_rej) begin
               state_next   = REPORT;
               verdict_next = mk_verdict(1'b0, 1'b0);
            end else if (core_acc) begin
               state_next   = REPORT;
               verdict_next = mk_verdict(1'b1, 1'b0);
            end else if (wd_expired) begin
               state_next   = REPORT;
               verdict_next = mk_verdict(1'b0, 1'b1);
            end
         end
         REPORT: begin
            if (handshake) state_next = RELEASE;
         end
         RELEASE: begin
            state_next = IDLE;
         end
         default: begin
            state_next = IDLE;
         end
      endcase
   end

   // State, registered outputs, length latch and saturating statistics
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_reg         <= IDLE;
         verdict_reg       <= mk_verdict(1'b0, 1'b0);
         core_rst_reg      <= 1'b1;
         verdict_valid_reg <= 1'b0;
         pkt_done_reg      <= 1'b0;
         busy_reg          <= 1'b0;
         plen_reg          <= '0;
         stat_acc_reg      <= '0;
         stat_rej_reg      <= '0;
      end else begin
         state_reg         <= state_next;
         verdict_reg       <= verdict_next;
         core_rst_reg      <= (state_next != RUN);
         verdict_valid_reg <= (state_next == REPORT);
         pkt_done_reg      <= (state_next == RELEASE);
         busy_reg          <= (state_next != IDLE);
         if (state_reg == LOAD) plen_reg <= pkt_len;
         if (handshake) begin
            if (verdict_reg.acc) begin
               if (~&stat_acc_reg) stat_acc_reg <= stat_acc_reg + 1'b1;
            end else begin
               if (~&stat_rej_reg) stat_rej_reg <= stat_rej_reg + 1'b1;
            end
         end
      end
   end

   assign pkt_done      = pkt_done_reg;
   assign core_rst      = core_rst_reg;
   assign core_plen     = plen_reg;
   assign verdict_valid = verdict_valid_reg;
   assign verdict_acc   = verdict_reg.acc;
   assign verdict_len   = plen_reg;
   assign stat_acc      = stat_acc_reg;
   assign stat_rej      = stat_rej_reg;
   assign busy          = busy_reg;

endmodule
